boot_word_loader: RTL and testbench
===================================

Name: boot_word_loader

Overview:
Parametrised serial bootloader receiver. The host drives a data pin and a bit strobe pin. The block assembles DATA_WIDTH-bit words and writes a framed program image into instruction memory at sequential addresses. Compared with the single-word receiver it adds:
- a length header
- a running checksum with pass/fail status
- an inter-bit timeout that resynchronises a partial word
- configurable word/address widths and bit order

It sits between the board bootloader pins and the ROM write port. The processor stays held in reset until `ready` goes high.

Parameters:
DATA_WIDTH, 32, bits per word (header, data, checksum).
ADDR_WIDTH, 12, memory address width; maximum image length is 2^ADDR_WIDTH words.
SYNC_STAGES, 2, synchroniser flops on each async pin (>=2).
MSB_FIRST, 1, 1 = first received bit is word MSB; 0 = LSB first.
CHECKSUM_EN, 1, 1 = trailing checksum word expected and compared.
TIMEOUT_CYCLES, 1000000, idle clk cycles mid-word before the partial word is discarded.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
dataOnPin  input  1  async bit strobe from host; a bit is sampled on its rising edge.
dataPin  input  1  async serial data from host.
out  output  DATA_WIDTH  word to write; valid when wEn=1.
addr  output  ADDR_WIDTH  write address; valid when wEn=1.
wEn  output  1  one-cycle write pulse per data word.
ready  output  1  level: image fully loaded (and checksum matched if enabled).
error  output  1  level: bad header length or checksum mismatch.
busy  output  1  level: a frame has started (bits received) and is not yet DONE/ERROR.

Behaviour:
- Reset (reset=0 at a clk edge):
  - out=0, addr=0, wEn=0, ready=0, error=0, busy=0.
  - State=HEADER; bit counter=0; word pointer=0; sum=0; timeout counter=0.
  - Synchroniser and edge-detect registers cleared.
  - Edge detection is masked for SYNC_STAGES+1 cycles after reset deasserts, so a strobe held high through reset produces no bit.
- Input path:
  - Both pins pass through SYNC_STAGES flops.
  - A rising edge = synced strobe 1 while previous synced strobe is 0 (cycle E).
  - Synced data is shifted in during cycle E, honouring MSB_FIRST.
  - Data changes between strobe edges have no effect.
- Word completion: when the DATA_WIDTH-th bit is shifted in cycle E, the assembled word is processed in cycle E+1 and the bit counter returns to 0.
- Timeout:
  - If bit counter != 0 and no edge occurs for TIMEOUT_CYCLES consecutive cycles, the bit counter is cleared.
  - FSM state, pointer and sum are unchanged.
  - The counter resets on every edge.
- FSM:
  - HEADER: on a word, N = word[ADDR_WIDTH:0]. If N==0 or N>2^ADDR_WIDTH -> ERROR; else -> DATA with pointer=0, sum=0.
  - DATA: on a word, in cycle E+1: wEn=1, out=word, addr=pointer; sum += word (mod 2^DATA_WIDTH); pointer++. After the N-th word -> CHECK if CHECKSUM_EN, else DONE. Only N=2^ADDR_WIDTH wraps the pointer, and only after the last write.
  - CHECK: on a word -> DONE if word==sum, else ERROR.
  - DONE: ready=1. All further edges are ignored; exit only via reset.
  - ERROR: error=1. All further edges are ignored; exit only via reset.
- Output timing and relations:
  - wEn is never high for two consecutive cycles. out and addr hold their last written values when wEn=0.
  - busy=1 from the first sampled bit of the header until DONE/ERROR is entered.
  - ready and error are never both 1.
- Reset mid-frame: abandons the frame completely; the next frame starts at HEADER with addr 0.

Test Plan:
1. DATA_WIDTH=32, ADDR_WIDTH=12. Send header 3, words 0x11111111, 0x22222222, 0xDEADBEEF, checksum 0x11E0F222 -> three wEn pulses at addr 0,1,2 with those words; ready=1, error=0, busy=0.
2. Same frame with checksum 0x11E0F223 -> the three writes still occur; error=1, ready=0; further strobes cause no wEn.
3. Header 0 -> error=1 with no wEn. After reset, header 4097 -> error=1. After reset, header 4096 -> busy stays 1 (DATA state), no error.
4. TIMEOUT_CYCLES=64: send 5 bits, idle 65 cycles, then header 1, word 0xA5A5A5A5, checksum 0xA5A5A5A5 -> single wEn at addr 0 with 0xA5A5A5A5; ready=1.
5. Reset low for 1 cycle after the 2nd data word of a 3-word frame -> all outputs 0 the next cycle. A new 1-word frame (0x00000007, checksum 7) writes addr 0 and sets ready=1.
6. dataOnPin held high through reset release; dataPin toggled between strobe edges; MSB_FIRST=0 with header 1, word 0x00000001 sent LSB first -> no spurious bit; out=0x00000001 at addr 0 and ready=1.

Source files
------------

// File: rtl/boot_word_loader.sv
// Serial bootloader receiver: it assembles words from a strobed data pin, checks a
// length header and an optional checksum, and writes the image to sequential addresses.
module boot_word_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int SYNC_STAGES    = 2,
    parameter int MSB_FIRST      = 1,
    parameter int CHECKSUM_EN    = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dataOnPin,
    input  logic                  dataPin,
    output logic [DATA_WIDTH-1:0] out,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wEn,
    output logic                  ready,
    output logic                  error,
    output logic                  busy
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MCW = $clog2(SYNC_STAGES + 2);
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_HEADER,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  strobe_sync;
    logic [SYNC_STAGES-1:0]  data_sync;
    logic                    strobe_prev;
    logic [MCW-1:0]          mask_cnt;
    logic                    strobe_edge;
    logic                    bit_in;
    logic                    accept;
    logic [BCW-1:0]          bit_cnt;
    logic [TCW-1:0]          idle_cnt;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [DATA_WIDTH-1:0]   shifted;
    logic                    word_valid;
    logic [ADDR_WIDTH:0]     hdr_len;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   last_ptr;
    logic [DATA_WIDTH-1:0]   sum;

    // Edge detection stays masked until the synchronisers have flushed, so a strobe
    // held high across reset release does not look like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            strobe_sync <= '0;
            data_sync   <= '0;
            strobe_prev <= 1'b0;
            mask_cnt    <= MCW'(SYNC_STAGES + 1);
        end else begin
            strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], dataOnPin};
            data_sync   <= {data_sync[SYNC_STAGES-2:0], dataPin};
            strobe_prev <= strobe_sync[SYNC_STAGES-1];
            if (mask_cnt != '0)
                mask_cnt <= mask_cnt - 1'b1;
        end
    end

    always_comb begin
        strobe_edge = strobe_sync[SYNC_STAGES-1] & ~strobe_prev & (mask_cnt == '0);
        bit_in      = data_sync[SYNC_STAGES-1];
        accept      = strobe_edge & (state != S_DONE) & (state != S_ERROR);
        if (MSB_FIRST != 0)
            shifted = {shreg[DATA_WIDTH-2:0], bit_in};
        else
            shifted = {bit_in, shreg[DATA_WIDTH-1:1]};
        hdr_len = shreg[ADDR_WIDTH:0];
    end

    // shreg holds the finished word during the cycle word_valid is high; the next
    // edge cannot arrive before then, so no separate word register is needed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            shreg      <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (accept) begin
                idle_cnt <= '0;
                shreg    <= shifted;
                if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                    bit_cnt    <= '0;
                    word_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (bit_cnt != '0) begin
                if (idle_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_HEADER;
            out      <= '0;
            addr     <= '0;
            wEn      <= 1'b0;
            ready    <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b0;
            ptr      <= '0;
            last_ptr <= '0;
            sum      <= '0;
        end else begin
            wEn <= 1'b0;
            if (accept && state == S_HEADER)
                busy <= 1'b1;
            if (word_valid) begin
                case (state)
                    S_HEADER: begin
                        if (hdr_len == '0 || hdr_len > MAX_LEN) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_DATA;
                            ptr      <= '0;
                            sum      <= '0;
                            last_ptr <= ADDR_WIDTH'(hdr_len - 1'b1);
                        end
                    end
                    S_DATA: begin
                        wEn  <= 1'b1;
                        out  <= shreg;
                        addr <= ptr;
                        sum  <= sum + shreg;
                        // A full 2^ADDR_WIDTH image wraps ptr to 0 here, after its last write.
                        ptr  <= ptr + 1'b1;
                        if (ptr == last_ptr) begin
                            if (CHECKSUM_EN != 0) begin
                                state <= S_CHECK;
                            end else begin
                                state <= S_DONE;
                                ready <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    S_CHECK: begin
                        busy <= 1'b0;
                        if (shreg == sum) begin
                            state <= S_DONE;
                            ready <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_word_loader.sv
// Directed bench for boot_word_loader: table-driven frames plus timeout, mid-frame reset
// and LSB-first / strobe-through-reset sequences.
module tb_boot_word_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic [1:0]  strobe = '0;
    logic [1:0]  dpin = '0;

    logic [31:0] out0, out1;
    logic [11:0] addr0, addr1;
    logic        wen0, wen1, ready0, ready1, error0, error1, busy0, busy1;

    boot_word_loader #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .SYNC_STAGES(2),
        .MSB_FIRST(1), .CHECKSUM_EN(1), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .reset(reset), .dataOnPin(strobe[0]), .dataPin(dpin[0]),
        .out(out0), .addr(addr0), .wEn(wen0), .ready(ready0), .error(error0), .busy(busy0)
    );

    boot_word_loader #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .SYNC_STAGES(2),
        .MSB_FIRST(0), .CHECKSUM_EN(1), .TIMEOUT_CYCLES(64)
    ) dut_lsb (
        .clk(clk), .reset(reset), .dataOnPin(strobe[1]), .dataPin(dpin[1]),
        .out(out1), .addr(addr1), .wEn(wen1), .ready(ready1), .error(error1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t  wq0[$];
    wr_t  wq1[$];
    logic pw0 = 1'b0;
    logic pw1 = 1'b0;

    always @(negedge clk) begin
        if (wen0) begin
            check("wen0_single_cycle", 64'(pw0), 64'd0);
            wq0.push_back('{a: addr0, d: out0});
        end
        if (wen1) begin
            check("wen1_single_cycle", 64'(pw1), 64'd0);
            wq1.push_back('{a: addr1, d: out1});
        end
        pw0 = wen0;
        pw1 = wen1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Data is flipped while the strobe is high and in the gap, so only the value
    // present at the rising edge should be captured.
    task automatic send_bit(input int which, input logic b);
        @(negedge clk);
        dpin[which] = b;
        idle(2);
        strobe[which] = 1'b1;
        idle(3);
        dpin[which] = ~b;
        idle(1);
        strobe[which] = 1'b0;
        idle(2);
    endtask

    task automatic send_word(input int which, input logic [31:0] w, input bit msb);
        for (int i = 0; i < 32; i++)
            send_bit(which, msb ? w[31-i] : w[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        check("reset_outputs0", {out0, 20'(addr0), wen0, ready0, error0, busy0}, 64'd0);
        reset = 1'b1;
        idle(5);
        wq0.delete();
        wq1.delete();
    endtask

    typedef struct {
        string       name;
        logic [31:0] hdr;
        int          nw;
        logic [31:0] w [3];
        bit          has_cks;
        logic [31:0] cks;
        logic        exp_ready;
        logic        exp_error;
        logic        exp_busy;
        bit          probe_after;
    } vec_t;

    vec_t vt [6];

    initial begin
        vt[0] = '{"good3", 32'd3, 3, '{32'h11111111, 32'h22222222, 32'hDEADBEEF},
                  1'b1, 32'h11E0F222, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[1] = '{"badcks", 32'd3, 3, '{32'h11111111, 32'h22222222, 32'hDEADBEEF},
                  1'b1, 32'h11E0F223, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[2] = '{"hdr0", 32'd0, 0, '{32'h0, 32'h0, 32'h0},
                  1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[3] = '{"hdr4097", 32'd4097, 0, '{32'h0, 32'h0, 32'h0},
                  1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{"hdr4096", 32'd4096, 0, '{32'h0, 32'h0, 32'h0},
                  1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        // Header bits above ADDR_WIDTH are ignored; the sum wraps modulo 2^32.
        vt[5] = '{"hdrhigh", 32'hFFFF0002, 2, '{32'h80000000, 32'h80000001, 32'h0},
                  1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            send_word(0, vt[v].hdr, 1'b1);
            for (int j = 0; j < vt[v].nw; j++)
                send_word(0, vt[v].w[j], 1'b1);
            if (vt[v].has_cks)
                send_word(0, vt[v].cks, 1'b1);
            idle(10);
            check({vt[v].name, "_ready"}, 64'(ready0), 64'(vt[v].exp_ready));
            check({vt[v].name, "_error"}, 64'(error0), 64'(vt[v].exp_error));
            check({vt[v].name, "_busy"}, 64'(busy0), 64'(vt[v].exp_busy));
            check({vt[v].name, "_nwrites"}, 64'(wq0.size()), 64'(vt[v].nw));
            for (int k = 0; k < vt[v].nw; k++) begin
                if (k < wq0.size()) begin
                    check({vt[v].name, "_addr"}, 64'(wq0[k].a), 64'(k));
                    check({vt[v].name, "_data"}, 64'(wq0[k].d), 64'(vt[v].w[k]));
                end
            end
            if (vt[v].probe_after) begin
                send_word(0, 32'hFFFFFFFF, 1'b1);
                idle(10);
                check({vt[v].name, "_post_nwrites"}, 64'(wq0.size()), 64'(vt[v].nw));
                check({vt[v].name, "_post_flags"}, 64'({ready0, error0, busy0}),
                      64'({vt[v].exp_ready, vt[v].exp_error, 1'b0}));
            end
        end

        // Partial word discarded by the inter-bit timeout.
        do_reset();
        for (int i = 0; i < 5; i++)
            send_bit(0, 1'b1);
        idle(70);
        check("tmo_busy_partial", 64'(busy0), 64'd1);
        send_word(0, 32'd1, 1'b1);
        send_word(0, 32'hA5A5A5A5, 1'b1);
        send_word(0, 32'hA5A5A5A5, 1'b1);
        idle(10);
        check("tmo_nwrites", 64'(wq0.size()), 64'd1);
        if (wq0.size() > 0)
            check("tmo_write", 64'(wq0[0]), 64'({12'd0, 32'hA5A5A5A5}));
        check("tmo_flags", 64'({ready0, error0, busy0}), 64'b100);

        // Reset pulse in the middle of a frame.
        do_reset();
        send_word(0, 32'd3, 1'b1);
        send_word(0, 32'h11111111, 1'b1);
        send_word(0, 32'h22222222, 1'b1);
        idle(3);
        check("midrst_nwrites", 64'(wq0.size()), 64'd2);
        check("midrst_state_before", {out0, 20'(addr0), wen0, ready0, error0, busy0},
              {32'h22222222, 20'd1, 4'b0001});
        reset = 1'b0;
        @(negedge clk);
        check("midrst_outputs", {out0, 20'(addr0), wen0, ready0, error0, busy0}, 64'd0);
        reset = 1'b1;
        idle(5);
        wq0.delete();
        send_word(0, 32'd1, 1'b1);
        send_word(0, 32'h00000007, 1'b1);
        send_word(0, 32'h00000007, 1'b1);
        idle(10);
        check("midrst_new_nwrites", 64'(wq0.size()), 64'd1);
        if (wq0.size() > 0)
            check("midrst_new_write", 64'(wq0[0]), 64'({12'd0, 32'h7}));
        check("midrst_new_flags", 64'({ready0, error0}), 64'b10);

        // Strobe held high across reset release on the LSB-first instance.
        @(negedge clk);
        strobe[1] = 1'b1;
        reset = 1'b0;
        idle(3);
        check("lsb_reset_outputs", {out1, 20'(addr1), wen1, ready1, error1, busy1}, 64'd0);
        reset = 1'b1;
        wq0.delete();
        wq1.delete();
        for (int i = 0; i < 10; i++) begin
            dpin[1] = ~dpin[1];
            @(negedge clk);
        end
        check("lsb_no_spurious_high", 64'(busy1), 64'd0);
        strobe[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dpin[1] = ~dpin[1];
            @(negedge clk);
        end
        check("lsb_no_spurious_low", 64'(busy1), 64'd0);
        send_word(1, 32'd1, 1'b0);
        send_word(1, 32'h00000001, 1'b0);
        send_word(1, 32'h00000001, 1'b0);
        idle(10);
        check("lsb_nwrites", 64'(wq1.size()), 64'd1);
        if (wq1.size() > 0)
            check("lsb_write", 64'(wq1[0]), 64'({12'd0, 32'h1}));
        check("lsb_flags", 64'({ready1, error1, busy1}), 64'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
